// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// fifo_wr_arbiter: shares one FIFO write port among P_REQ producers sending 1- or 2-byte frames.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fifo_wr_arbiter #(
  parameter int P_DATA = 8,
  parameter int P_REQ  = 2
) (
  input  logic                      w_clk,
  input  logic                      w_rst,
  input  logic [P_REQ-1:0]          rq_valid,
  input  logic [P_REQ-1:0]          rq_two,
  input  logic [P_REQ*2*P_DATA-1:0] rq_data,
  input  logic                      w_full,
  output logic                      w_inc,
  output logic [P_DATA-1:0]         w_data,
  output logic [P_REQ-1:0]          rq_ack,
  output logic [1:0]                grant_id,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } state_t;

  state_t              state;
  logic [2*P_DATA-1:0] frame_q;
  logic                two_q;

  logic                win_found;
  logic [1:0]          win_id;
  logic                win_two;
  logic [2*P_DATA-1:0] win_frame;
  logic                last_byte;

`ifdef FIFO_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last to overwrite.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_two   = 1'b0;
    win_frame = '0;
    for (int i = P_REQ - 1; i >= 0; i--) begin
      if (rq_valid[i]) begin
        win_found = 1'b1;
        win_id    = 2'(i);
        win_two   = rq_two[i];
        win_frame = rq_data[i*2*P_DATA +: 2*P_DATA];
      end
    end
  end
`else
  logic [1:0] last_grant;

  // Walk candidates last_grant+1, +2, ... with wrap-around; the first valid one wins.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_id    = '0;
    win_two   = 1'b0;
    win_frame = '0;
    for (int k = 1; k <= P_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= P_REQ) cand = cand - P_REQ;
      for (int i = 0; i < P_REQ; i++) begin
        if (!win_found && (cand == i) && rq_valid[i]) begin
          win_found = 1'b1;
          win_id    = 2'(i);
          win_two   = rq_two[i];
          win_frame = rq_data[i*2*P_DATA +: 2*P_DATA];
        end
      end
    end
  end
`endif

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state    <= IDLE;
      grant_id <= '0;
      frame_q  <= '0;
      two_q    <= 1'b0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      last_grant <= 2'(P_REQ - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state    <= BYTE0;
            grant_id <= win_id;
            frame_q  <= win_frame;
            two_q    <= win_two;
`ifndef FIFO_ARB_FIXED_PRIO_EN
            last_grant <= win_id;
`endif
          end
        end
        BYTE0: if (!w_full) state <= two_q ? BYTE1 : IDLE;
        BYTE1: if (!w_full) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign w_inc     = busy & ~w_full;
  assign last_byte = (state == BYTE1) | ((state == BYTE0) & ~two_q);

  always_comb begin
    w_data = '0;
    if (state == BYTE0)      w_data = frame_q[P_DATA-1:0];
    else if (state == BYTE1) w_data = frame_q[2*P_DATA-1:P_DATA];
  end

  always_comb begin
    rq_ack = '0;
    for (int i = 0; i < P_REQ; i++) begin
      rq_ack[i] = last_byte & ~w_full & (grant_id == 2'(i));
    end
  end

endmodule
`default_nettype wire
